// File: rtl/if_fetch.sv
// Instruction fetch responder: turns one PC into four byte reads and
// assembles a little-endian instruction, stalling PC until handoff.
module if_fetch #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              stall_in,
    input  logic              flush_in,
    output logic              stall_req_out,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic              mem_ready_in,
    input  logic              mem_valid_in,
    input  logic [7:0]        mem_data_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic [INST_W-1:0] inst_out,
    output logic              inst_valid_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN,
        S_RELOAD
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        issue_q, issue_d;
    logic [2:0]        ret_q, ret_d;
    logic [2:0]        outst_q, outst_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              hs;
    logic              rtn;

    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        issue_d        = issue_q;
        ret_d          = ret_q;
        outst_d        = outst_q;
        inst_d         = inst_q;
        stall_req_out  = 1'b1;
        mem_req_out    = 1'b0;
        inst_valid_out = 1'b0;
        hs             = 1'b0;
        rtn            = mem_valid_in && rdy_in;

        unique case (state_q)
            S_IDLE: begin
                base_d  = pc_in;
                issue_d = 3'd0;
                ret_d   = 3'd0;
                outst_d = 3'd0;
                state_d = S_REQ;
            end
            S_REQ, S_WAIT: begin
                mem_req_out = (state_q == S_REQ) && !flush_in && rdy_in;
                hs = mem_req_out && mem_ready_in;
                if (rtn) begin
                    inst_d[{ret_q[1:0], 3'b000} +: 8] = mem_data_in;
                    ret_d = ret_q + 3'd1;
                end
                if (hs) begin
                    issue_d = issue_q + 3'd1;
                end
                outst_d = outst_q + {2'b00, hs} - {2'b00, rtn};
                // a flush must still account for this cycle's return
                if (flush_in) begin
                    state_d = (outst_d != 3'd0) ? S_DRAIN : S_RELOAD;
                end else if (state_q == S_REQ && issue_d == 3'd4) begin
                    state_d = S_WAIT;
                end else if (state_q == S_WAIT && ret_d == 3'd4) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                inst_valid_out = !flush_in;
                stall_req_out  = stall_in;
                if (flush_in) begin
                    state_d = stall_in ? S_RELOAD : S_IDLE;
                end else if (!stall_in) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                outst_d = outst_q - {2'b00, rtn};
                if (outst_d == 3'd0) begin
                    state_d = S_RELOAD;
                end
            end
            S_RELOAD: begin
                stall_req_out = 1'b0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // global not-ready freezes every register
        if (!rdy_in) begin
            state_d = state_q;
            base_d  = base_q;
            issue_d = issue_q;
            ret_d   = ret_q;
            outst_d = outst_q;
            inst_d  = inst_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            issue_q <= 3'd0;
            ret_q   <= 3'd0;
            outst_q <= 3'd0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
            outst_q <= outst_d;
            inst_q  <= inst_d;
        end
    end

    assign mem_addr_out = base_q + {{(ADDR_W-3){1'b0}}, issue_q};
    assign pc_out       = base_q;
    assign inst_out     = inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: in-order byte memory, PC model and per-cycle
// transaction-level checks plus literal expectations.
module tb_if_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] pc_in;
    logic        stall_in;
    logic        flush_in;
    logic        stall_req_out;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_ready_in;
    logic        mem_valid_in;
    logic [7:0]  mem_data_in;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid_out;

    if_fetch #(.ADDR_W(32), .INST_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .pc_in(pc_in), .stall_in(stall_in), .flush_in(flush_in),
        .stall_req_out(stall_req_out), .mem_req_out(mem_req_out),
        .mem_addr_out(mem_addr_out), .mem_ready_in(mem_ready_in),
        .mem_valid_in(mem_valid_in), .mem_data_in(mem_data_in),
        .pc_out(pc_out), .inst_out(inst_out),
        .inst_valid_out(inst_valid_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic [7:0]  mem [512];
    pend_t       q[$];
    int          vectors = 0;
    int          errs = 0;
    int          cyc = 0;
    logic [31:0] pc = 0;
    logic [31:0] jmp_target = 0;
    bit          jmp_pending = 0;
    int          f_issued = 0;
    int          f_returned = 0;
    bit          killed = 0;
    int          lat = 1;
    int          ready_mode = 0;
    int          ready_limit = 4;
    bit          hold_ret = 0;
    bit          stall_v = 0;
    bit          flush_v = 0;
    bit          rdy_v = 1;

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] b;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            b = a + 32'(k);
            w[8*k +: 8] = mem[b[8:0]];
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h expected=%h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic step();
        bit exp_valid;
        bit exp_stall;
        bit hs;
        @(negedge clk_in);
        rdy_in   = rdy_v;
        stall_in = stall_v;
        flush_in = flush_v;
        pc_in    = pc;
        case (ready_mode)
            1:       mem_ready_in = cyc[0];
            2:       mem_ready_in = (f_issued < ready_limit);
            default: mem_ready_in = 1'b1;
        endcase
        if (rdy_v && !hold_ret && q.size() > 0 && q[0].due <= cyc) begin
            mem_valid_in = 1'b1;
            mem_data_in  = mem[q[0].addr[8:0]];
        end else begin
            mem_valid_in = 1'b0;
            mem_data_in  = 8'hEE;
        end
        #1;
        exp_valid = (f_returned == 4) && !killed && !flush_v;
        if (f_returned == 4 && !killed) exp_stall = stall_v;
        else if (killed && q.size() == 0) exp_stall = 1'b0;
        else exp_stall = 1'b1;
        chk("stall_req", 32'(stall_req_out), 32'(exp_stall));
        chk("inst_valid", 32'(inst_valid_out), 32'(exp_valid));
        if (exp_valid) begin
            chk("pc_out", pc_out, pc);
            chk("inst_out", inst_out, word(pc));
            chk("n_issued", 32'(f_issued), 32'd4);
        end
        if (mem_req_out) begin
            chk("req_addr", mem_addr_out, pc + 32'(f_issued));
            chk("req_cnt_ok", 32'(f_issued < 4), 32'd1);
        end
        if (flush_v || !rdy_v || killed) begin
            chk("req_gate", 32'(mem_req_out), 32'd0);
        end
        hs = mem_req_out && mem_ready_in;
        if (hs) begin
            q.push_back('{addr: mem_addr_out, due: cyc + lat});
            f_issued++;
        end
        if (mem_valid_in) begin
            void'(q.pop_front());
            f_returned++;
        end
        if (flush_v && rdy_v) killed = 1'b1;
        if (rdy_v && !stall_req_out) begin
            if (jmp_pending) begin
                pc = jmp_target;
                jmp_pending = 1'b0;
            end else begin
                pc = pc + 32'd4;
            end
            f_issued = 0;
            f_returned = 0;
            killed = 1'b0;
        end
        cyc++;
    endtask

    task automatic run_to_handoff(input string name);
        for (int i = 0; i < 200; i++) begin
            step();
            if (inst_valid_out && !stall_v) return;
        end
        chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_to_done(input string name);
        for (int i = 0; i < 200; i++) begin
            step();
            if (f_returned == 4) return;
        end
        chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h00; mem[6] = 8'h20; mem[7] = 8'h00;
        mem[8] = 8'hB7; mem[9] = 8'h02; mem[10] = 8'h00; mem[11] = 8'h10;
        mem[256] = 8'h6F; mem[257] = 8'h00;
        mem[258] = 8'h00; mem[259] = 8'h00;

        rst_in = 1'b0; rdy_in = 1'b1; pc_in = '0; stall_in = 1'b0;
        flush_in = 1'b0; mem_ready_in = 1'b0; mem_valid_in = 1'b0;
        mem_data_in = '0;
        #1;
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_inst", inst_out, 32'd0);
        chk("rst_valid", 32'(inst_valid_out), 32'd0);
        chk("rst_req", 32'(mem_req_out), 32'd0);
        chk("rst_addr", mem_addr_out, 32'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        #2 rst_in = 1'b1;

        // best case: one word from address 0
        for (int c = 0; c <= 6; c++) begin
            step();
            if (c >= 1 && c <= 4) begin
                chk("t1_req", 32'(mem_req_out), 32'd1);
                chk("t1_addr", mem_addr_out, 32'(c - 1));
            end
        end
        chk("t1_valid", 32'(inst_valid_out), 32'd1);
        chk("t1_inst", inst_out, 32'h00100513);
        chk("t1_pc", pc_out, 32'd0);
        chk("t1_stall", 32'(stall_req_out), 32'd0);
        run_to_handoff("t1b");
        chk("t1b_pc", pc_out, 32'd4);
        chk("t1b_inst", inst_out, 32'h00200093);

        // alternating ready, latency 3
        ready_mode = 1; lat = 3;
        run_to_handoff("t2");
        chk("t2_pc", pc_out, 32'd8);
        chk("t2_inst", inst_out, 32'h100002B7);

        // DONE held by downstream stall
        ready_mode = 0; lat = 1;
        run_to_done("t3");
        stall_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_stall", 32'(stall_req_out), 32'd1);
        end
        stall_v = 1'b0;
        step();
        chk("t3_handoff", 32'(stall_req_out), 32'd0);

        // flush after 2 issued / 1 returned
        ready_mode = 2; ready_limit = 2; lat = 1;
        for (int i = 0; i < 50; i++) begin
            if (f_issued == 2 && f_returned == 1) break;
            step();
        end
        chk("t4_pre", 32'(f_issued * 10 + f_returned), 32'd21);
        flush_v = 1'b1; hold_ret = 1'b1;
        jmp_pending = 1'b1; jmp_target = 32'h100;
        step();
        chk("t4_req_off", 32'(mem_req_out), 32'd0);
        flush_v = 1'b0; hold_ret = 1'b0; ready_mode = 0;
        run_to_handoff("t4");
        chk("t4_pc", pc_out, 32'h100);
        chk("t4_inst", inst_out, 32'h0000006F);

        // flush while DONE and not stalled
        run_to_done("t5");
        flush_v = 1'b1; jmp_pending = 1'b1; jmp_target = 32'h8;
        step();
        chk("t5_valid", 32'(inst_valid_out), 32'd0);
        chk("t5_stall", 32'(stall_req_out), 32'd0);
        flush_v = 1'b0;
        run_to_handoff("t5");
        chk("t5_pc", pc_out, 32'h8);
        chk("t5_inst", inst_out, 32'h100002B7);

        // global not-ready mid fetch
        lat = 2;
        step();
        step();
        rdy_v = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rdy_v = 1'b1;
        run_to_handoff("t6");
        chk("t6_pc", pc_out, 32'hC);

        // asynchronous reset mid request phase
        step();
        step();
        #2 rst_in = 1'b0;
        #1;
        chk("t7_pc", pc_out, 32'd0);
        chk("t7_inst", inst_out, 32'd0);
        chk("t7_valid", 32'(inst_valid_out), 32'd0);
        chk("t7_req", 32'(mem_req_out), 32'd0);
        chk("t7_addr", mem_addr_out, 32'd0);
        q.delete();
        f_issued = 0; f_returned = 0; killed = 1'b0;
        pc = 32'h20;
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        run_to_handoff("t7");
        chk("t7_after_pc", pc_out, 32'h20);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end

endmodule
